// File: rtl/fifo_ring_buffer.sv
// ============================================================================
// Module      : fifo_ring_buffer
// Description : Single-clock ring-buffer FIFO with registered or FWFT read,
//               almost-full/almost-empty thresholds and sticky OVF/UDF flags.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ring_buffer #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         Rst_n,
    input  logic                         EN,
    input  logic                         Clr,
    input  logic                         WR,
    input  logic                         RD,
    input  logic [WIDTH-1:0]             dataIn,
    output logic [WIDTH-1:0]             dataOut,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         ALMOST_EMPTY,
    output logic                         ALMOST_FULL,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         OVF,
    output logic                         UDF
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wptr_q, wptr_d;
    logic [c_PTR_W-1:0] rptr_q, rptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               w_clr;
    logic               w_push;
    logic               w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign EMPTY        = (count_q == '0);
    assign FULL         = (count_q == c_CNT_W'(DEPTH));
    assign ALMOST_EMPTY = (count_q <= c_CNT_W'(AE_LEVEL));
    assign ALMOST_FULL  = (count_q >= c_CNT_W'(AF_LEVEL));
    assign COUNT        = count_q;
    assign OVF          = ovf_q;
    assign UDF          = udf_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts RD+WR.
    assign w_clr  = EN & Clr;
    assign w_pop  = EN & RD & ~Clr & ~EMPTY;
    assign w_push = EN & WR & ~Clr & (~FULL | w_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (w_clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (w_push) wptr_d = f_next(wptr_q);
            if (w_pop)  rptr_d = f_next(rptr_q);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (EN & WR & ~w_push) ovf_d = 1'b1;
            if (EN & RD & ~w_pop)  udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q] <= dataIn;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dataOut = EMPTY ? '0 : mem_q[rptr_q];
        end else begin : g_reg_read
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge Rst_n) begin
                if (!Rst_n)     dout_q <= '0;
                else if (w_clr) dout_q <= '0;
                else if (w_pop) dout_q <= mem_q[rptr_q];
            end
            assign dataOut = dout_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_ring_buffer.sv
// ============================================================================
// Module      : tb_fifo_ring_buffer
// Description : Self-checking bench for fifo_ring_buffer (registered, FWFT and
//               DEPTH=3 instances) using a queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_ring_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] din = 8'h00;
    int         sel = 0;

    logic       en0, en1, en2;
    logic [7:0] dout0, dout1, dout2;
    logic       e0, e1, e2, f0, f1, f2, ae0, ae1, ae2, af0, af1, af2;
    logic       ov0, ov1, ov2, ud0, ud1, ud2;
    logic [2:0] cnt0, cnt1;
    logic [1:0] cnt2;

    logic [7:0] obs_dout;
    logic [2:0] obs_cnt;
    logic       obs_e, obs_f, obs_ae, obs_af, obs_ov, obs_ud;

    logic [7:0] q[$];
    int         mdepth = 4;
    bit         mfwft = 1'b0;
    logic       movf = 1'b0;
    logic       mudf = 1'b0;
    logic [7:0] mdout = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign en0 = en && (sel == 0);
    assign en1 = en && (sel == 1);
    assign en2 = en && (sel == 2);

    fifo_ring_buffer #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_reg (
        .clk(clk), .Rst_n(rst_n), .EN(en0), .Clr(clr), .WR(wr), .RD(rd),
        .dataIn(din), .dataOut(dout0), .EMPTY(e0), .FULL(f0),
        .ALMOST_EMPTY(ae0), .ALMOST_FULL(af0), .COUNT(cnt0), .OVF(ov0), .UDF(ud0));

    fifo_ring_buffer #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .Rst_n(rst_n), .EN(en1), .Clr(clr), .WR(wr), .RD(rd),
        .dataIn(din), .dataOut(dout1), .EMPTY(e1), .FULL(f1),
        .ALMOST_EMPTY(ae1), .ALMOST_FULL(af1), .COUNT(cnt1), .OVF(ov1), .UDF(ud1));

    fifo_ring_buffer #(.WIDTH(8), .DEPTH(3), .FWFT(0)) u_d3 (
        .clk(clk), .Rst_n(rst_n), .EN(en2), .Clr(clr), .WR(wr), .RD(rd),
        .dataIn(din), .dataOut(dout2), .EMPTY(e2), .FULL(f2),
        .ALMOST_EMPTY(ae2), .ALMOST_FULL(af2), .COUNT(cnt2), .OVF(ov2), .UDF(ud2));

    always_comb begin
        obs_dout = dout0; obs_cnt = cnt0; obs_e = e0; obs_f = f0;
        obs_ae = ae0; obs_af = af0; obs_ov = ov0; obs_ud = ud0;
        case (sel)
            1: begin
                obs_dout = dout1; obs_cnt = cnt1; obs_e = e1; obs_f = f1;
                obs_ae = ae1; obs_af = af1; obs_ov = ov1; obs_ud = ud1;
            end
            2: begin
                obs_dout = dout2; obs_cnt = {1'b0, cnt2}; obs_e = e2; obs_f = f2;
                obs_ae = ae2; obs_af = af2; obs_ov = ov2; obs_ud = ud2;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] ed;
        int         n;
        n = q.size();
        if (mfwft) ed = (n != 0) ? q[0] : 8'h00;
        else       ed = mdout;
        chk({tag, ":count"}, 32'(obs_cnt), 32'(n));
        chk({tag, ":empty"}, 32'(obs_e),   32'(n == 0));
        chk({tag, ":full"},  32'(obs_f),   32'(n == mdepth));
        chk({tag, ":aempty"}, 32'(obs_ae), 32'(n <= 1));
        chk({tag, ":afull"}, 32'(obs_af),  32'(n >= mdepth - 1));
        chk({tag, ":ovf"},   32'(obs_ov),  32'(movf));
        chk({tag, ":udf"},   32'(obs_ud),  32'(mudf));
        chk({tag, ":dout"},  32'(obs_dout), 32'(ed));
    endtask

    task automatic model_reset();
        q.delete();
        movf  = 1'b0;
        mudf  = 1'b0;
        mdout = 8'h00;
    endtask

    // Expected acceptance is decided from the model state before the edge.
    task automatic cyc(input logic w, input logic r, input logic c,
                       input logic [7:0] d, input string tag);
        logic       pop, push;
        logic [7:0] popped;
        wr = w; rd = r; clr = c; din = d;
        pop  = en && r && !c && (q.size() != 0);
        push = en && w && !c && ((q.size() < mdepth) || pop);
        @(posedge clk);
        #1;
        if (en && c) begin
            model_reset();
        end else if (en) begin
            if (pop) begin
                popped = q.pop_front();
                if (!mfwft) mdout = popped;
            end
            if (push) q.push_back(d);
            if (w && !push) movf = 1'b1;
            if (r && !pop)  mudf = 1'b1;
        end
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
        check_all(tag);
    endtask

    task automatic reset_to(input int s, input int depth, input bit fwft);
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        #2;
        sel    = s;
        mdepth = depth;
        mfwft  = fwft;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    initial begin
        #12;
        check_all("por");
        rst_n = 1'b1;
        en    = 1'b1;

        // Registered-read instance: fill, overflow, drain in order.
        cyc(1, 0, 0, 8'h11, "wr11");
        cyc(1, 0, 0, 8'h22, "wr22");
        cyc(1, 0, 0, 8'h33, "wr33");
        cyc(1, 0, 0, 8'h44, "wr44");
        cyc(1, 0, 0, 8'h55, "wr55_ovf");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00, "drain1");
        cyc(0, 1, 0, 8'h00, "rd_empty_udf");
        cyc(0, 0, 1, 8'h00, "clr");
        cyc(0, 1, 0, 8'h00, "rd_empty_after_clr");
        cyc(0, 0, 1, 8'h00, "clr2");

        // Full with simultaneous read and write: occupancy stays at DEPTH.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'(8'h01 + i), "fill");
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 8'hAA, "full_rw");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00, "drain_aa");
        cyc(1, 1, 0, 8'hBB, "empty_rw");
        cyc(0, 1, 0, 8'h00, "rd_bb");

        // Asynchronous reset between edges discards stored words.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'(8'h61 + i), "pre_rst");
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 8'h77, "wr77");
        cyc(0, 1, 0, 8'h00, "rd77");

        // FWFT instance.
        reset_to(1, 4, 1'b1);
        cyc(1, 0, 0, 8'h5A, "fwft_wr");
        cyc(0, 0, 0, 8'h00, "fwft_idle");
        cyc(0, 1, 0, 8'h00, "fwft_rd");
        cyc(1, 0, 0, 8'hC1, "fwft_w1");
        cyc(1, 0, 0, 8'hC2, "fwft_w2");
        cyc(1, 1, 0, 8'hC3, "fwft_rw");
        cyc(0, 1, 0, 8'h00, "fwft_r2");
        cyc(0, 1, 0, 8'h00, "fwft_r3");
        cyc(0, 1, 0, 8'h00, "fwft_udf");

        // DEPTH=3 instance: enable gating, then wrap at index 2 -> 0.
        reset_to(2, 3, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'hEE, "en_off");
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, 0, 8'(8'h30 + i), "d3_wr");
            cyc(0, 1, 0, 8'h00, "d3_rd");
        end
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'(8'h40 + i), "d3_fill");
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h00, "d3_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_ring_buffer.md
FIFO_RING_BUFFER -- requirements
Module: fifo_ring_buffer

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of storage entries (>=2, power of two not required).
REQ-003 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 Parameter AF_LEVEL, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-005 Parameter AE_LEVEL, default 1, almost-empty threshold (0..DEPTH-1).
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 Rst_n  input  1  reset, asynchronous, active-low.
REQ-008 EN  input  1  global enable; when 0 the block SHALL hold all state.
REQ-009 Clr  input  1  synchronous flush, qualified by EN.
REQ-010 WR  input  1  write request.
REQ-011 RD  input  1  read request.
REQ-012 dataIn  input  WIDTH  write data.
REQ-013 dataOut  output  WIDTH  read data.
REQ-014 EMPTY, FULL  output  1 each  COUNT==0, COUNT==DEPTH.
REQ-015 ALMOST_EMPTY, ALMOST_FULL  output  1 each  COUNT<=AE_LEVEL, COUNT>=AF_LEVEL.
REQ-016 COUNT  output  $clog2(DEPTH+1)  current occupancy.
REQ-017 OVF, UDF  output  1 each  sticky overflow / underflow flags.

Function
REQ-018 Status outputs SHALL be combinational from registered COUNT/flags only (no input-to-status path).
REQ-019 Read accepted (pop) SHALL be EN & RD & !Clr & !EMPTY.
REQ-020 Write accepted (push) SHALL be EN & WR & !Clr & (!FULL | pop); full plus simultaneous RD/WR: both accepted, COUNT unchanged.
REQ-021 Empty plus simultaneous RD/WR: write accepted, read rejected, UDF set, COUNT becomes 1.
REQ-022 Push: mem[wptr] <= dataIn, wptr advances; pop: rptr advances; each pointer wraps DEPTH-1 -> 0.
REQ-023 COUNT SHALL change by +1 (push only), -1 (pop only), 0 (both or neither); never exceeds DEPTH or goes below 0.
REQ-024 FWFT=0: on pop, dataOut <= mem[rptr] at that edge (1-cycle latency); otherwise dataOut holds.
REQ-025 FWFT=1: dataOut SHALL equal mem[rptr] combinationally while !EMPTY, 0 while EMPTY; pop discards that word.
REQ-026 OVF SHALL set when EN & WR & !Clr and push rejected; UDF when EN & RD & !Clr and pop rejected; both hold until Clr or reset.
REQ-027 Clr (with EN=1) SHALL zero pointers, COUNT, OVF, UDF and registered dataOut, overriding RD/WR that cycle; memory contents need not clear.
REQ-028 EN=0 SHALL suppress push, pop, Clr and flag updates regardless of other inputs.

Reset
REQ-029 Rst_n low SHALL immediately, without clk, force pointers=0, COUNT=0, OVF=UDF=0, registered dataOut=0.
REQ-030 Reset outputs: EMPTY=1, FULL=0, ALMOST_EMPTY=1 (AE_LEVEL>=0), ALMOST_FULL=0, dataOut=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored words; after release first read returns first word written post-release.
REQ-032 Deassertion of Rst_n SHALL be followed by normal operation from the next rising clk edge.

Verification (WIDTH=8, DEPTH=4, defaults unless stated)
REQ-033 Write 0x11,0x22,0x33,0x44 then fifth write 0x55 -> FULL=1, COUNT=4, OVF=1, ALMOST_FULL=1 from COUNT=3; four reads return 0x11..0x44 in order, 0x55 never appears.
REQ-034 FWFT=0, empty, RD=1 -> UDF=1, dataOut stays 0x00, COUNT=0; then Clr=1 one cycle -> UDF=0.
REQ-035 Full, RD=WR=1 with dataIn=0xAA for 6 cycles -> COUNT stays 4, no OVF, pointers wrap, subsequent drain ends with 0xAA x4.
REQ-036 FWFT=1, write 0x5A -> dataOut=0x5A in the cycle after the write with no RD; RD=1 -> next cycle EMPTY=1, dataOut=0x00.
REQ-037 Write 3 words, assert Rst_n low between clock edges -> COUNT=0, EMPTY=1 before next edge; release, write 0x77, read -> 0x77.
REQ-038 DEPTH=3: EN=0 with WR=1 for 5 cycles -> COUNT unchanged, OVF=0; then 7 writes/7 reads interleaved verify wrap at index 2 -> 0 with data order preserved.
